spi_slave_core: RTL and testbench

Byte-oriented SPI responder: the slave-side counterpart of the SPI controller in this directory, attached to an external SPI master through pins. It oversamples SCK/CS_N/MOSI on the system clock, shifts out a word from a one-entry TX holding register while shifting in a word to an RX register. It presents both to the local logic via valid/ready handshakes. Used as a configuration/debug port into the MCU.

---
 rtl/spi_slv_pkg.sv | 18 +
 rtl/spi_slv_sync.sv | 44 ++++
 rtl/spi_slave_core.sv | 151 +++++++++++++++
 tb/tb_spi_slave_core.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared types and helpers for the SPI slave core: FSM states, edge selection
// from CPOL/CPHA, and the all-ones fill used when the TX holding register is empty.
package spi_slv_pkg;

    typedef enum logic {
        StIdle,
        StXfer
    } state_e;

    localparam int unsigned MAX_W = 64;
    localparam logic [MAX_W-1:0] FILL_ONES = '1;

    // Leading edge is the one leaving CPOL; CPHA=0 samples on it, CPHA=1 on the other.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Pin synchronizers for SCK, CS_N and MOSI plus edge detection on the
// synchronized SCK and CS_N against one delayed copy.
module spi_slv_sync #(
    parameter int unsigned STAGES = 2,
    parameter bit          CPOL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_n_o,
    output logic cs_fall_o,
    output logic mosi_o
);

    logic [STAGES-1:0] sck_q, cs_n_q, mosi_q;
    logic              sck_dly_q, cs_n_dly_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q      <= {STAGES{CPOL}};
            cs_n_q     <= '1;
            mosi_q     <= '0;
            sck_dly_q  <= CPOL;
            cs_n_dly_q <= 1'b1;
        end else begin
            sck_q      <= {sck_q[STAGES-2:0], sck_i};
            cs_n_q     <= {cs_n_q[STAGES-2:0], cs_n_i};
            mosi_q     <= {mosi_q[STAGES-2:0], mosi_i};
            sck_dly_q  <= sck_q[STAGES-1];
            cs_n_dly_q <= cs_n_q[STAGES-1];
        end
    end

    assign sck_rise_o = sck_q[STAGES-1] & ~sck_dly_q;
    assign sck_fall_o = ~sck_q[STAGES-1] & sck_dly_q;
    assign cs_n_o     = cs_n_q[STAGES-1];
    assign cs_fall_o  = ~cs_n_q[STAGES-1] & cs_n_dly_q;
    assign mosi_o     = mosi_q[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// Byte-oriented SPI slave with one-entry TX holding register and RX valid/ready output.
// Define SPI_SLV_STATUS_EN to add sticky overrun_o/underrun_o flags and clr_status_i.
module spi_slave_core
    import spi_slv_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o
`ifdef SPI_SLV_STATUS_EN
    ,
    output logic              overrun_o,
    output logic              underrun_o,
    input  logic              clr_status_i
`endif
);

    localparam int unsigned       CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    state_e state_q, state_d;

    logic              sck_rise, sck_fall, cs_n_s, cs_fall, mosi_s;
    logic              active, sample_edge, shift_edge, sample_last, load, take;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] tx_shift_q, hold_q, rx_data_q;
    logic [DATA_W-2:0] rx_shift_q;
    logic              hold_full_q, rx_valid_q;

    spi_slv_sync #(
        .STAGES (SYNC_STAGES),
        .CPOL   (CPOL)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (spi_sck_i),
        .cs_n_i     (spi_cs_n_i),
        .mosi_i     (spi_mosi_i),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_n_o     (cs_n_s),
        .cs_fall_o  (cs_fall),
        .mosi_o     (mosi_s)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_n_s) begin
            state_d = StIdle;
        end else if (state_q == StIdle && cs_fall) begin
            state_d = StXfer;
        end
    end

    assign active      = (state_q == StXfer) && !cs_n_s;
    assign sample_edge = active && (SAMPLE_RISE ? sck_rise : sck_fall);
    assign shift_edge  = active && (SAMPLE_RISE ? sck_fall : sck_rise);
    assign sample_last = sample_edge && (bit_cnt_q == LAST_BIT);
    // A shift edge with the counter at zero starts a new word in both phases.
    assign load        = (!CPHA && state_q == StIdle && cs_fall)
                       || (shift_edge && bit_cnt_q == '0);
    assign take        = rx_valid_q && rx_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            if (load) begin
                tx_shift_q <= hold_full_q ? hold_q : FILL_ONES[DATA_W-1:0];
            end else if (shift_edge) begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
            end

            if (load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (tx_valid_i && !hold_full_q) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end

            if (cs_n_s) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (sample_edge) begin
                rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
                bit_cnt_q  <= sample_last ? '0 : bit_cnt_q + 1'b1;
            end

            if (sample_last) begin
                rx_data_q  <= {rx_shift_q, mosi_s};
                rx_valid_q <= 1'b1;
            end else if (take) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLV_STATUS_EN
    logic overrun_q, underrun_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (sample_last && rx_valid_q && !rx_ready_i) overrun_q <= 1'b1;
            else if (clr_status_i)                        overrun_q <= 1'b0;
            if (load && !hold_full_q)                     underrun_q <= 1'b1;
            else if (clr_status_i)                        underrun_q <= 1'b0;
        end
    end

    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;
`endif

    assign spi_miso_o    = tx_shift_q[DATA_W-1];
    assign spi_miso_oe_o = (state_q == StXfer);
    assign busy_o        = (state_q == StXfer);
    assign tx_ready_o    = !hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one mode-0 and one mode-3 instance driven by a
// bit-banged SPI master; table of single-word frames plus multi-cycle sequences.
module tb_spi_slave_core;

    localparam int unsigned W = 8;
    localparam int H = 6;  // SCK half period in clk cycles

    logic clk = 1'b0;
    logic rst;
    logic [1:0] sck, cs_n, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_ready, busy;
    logic [1:0][W-1:0] tx_data, rx_data;
`ifdef SPI_SLV_STATUS_EN
    logic [1:0] overrun, underrun, clr_status;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(W), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_mode0 (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck[0]),
        .spi_cs_n_i    (cs_n[0]),
        .spi_mosi_i    (mosi[0]),
        .spi_miso_o    (miso[0]),
        .spi_miso_oe_o (miso_oe[0]),
        .tx_data_i     (tx_data[0]),
        .tx_valid_i    (tx_valid[0]),
        .tx_ready_o    (tx_ready[0]),
        .rx_data_o     (rx_data[0]),
        .rx_valid_o    (rx_valid[0]),
        .rx_ready_i    (rx_ready[0]),
        .busy_o        (busy[0])
`ifdef SPI_SLV_STATUS_EN
        ,
        .overrun_o     (overrun[0]),
        .underrun_o    (underrun[0]),
        .clr_status_i  (clr_status[0])
`endif
    );

    spi_slave_core #(.DATA_W(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_mode3 (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck[1]),
        .spi_cs_n_i    (cs_n[1]),
        .spi_mosi_i    (mosi[1]),
        .spi_miso_o    (miso[1]),
        .spi_miso_oe_o (miso_oe[1]),
        .tx_data_i     (tx_data[1]),
        .tx_valid_i    (tx_valid[1]),
        .tx_ready_o    (tx_ready[1]),
        .rx_data_o     (rx_data[1]),
        .rx_valid_o    (rx_valid[1]),
        .rx_ready_i    (rx_ready[1]),
        .busy_o        (busy[1])
`ifdef SPI_SLV_STATUS_EN
        ,
        .overrun_o     (overrun[1]),
        .underrun_o    (underrun[1]),
        .clr_status_i  (clr_status[1])
`endif
    );

    typedef struct {
        int         m;
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic       exp_und;
    } vec_t;

    vec_t vecs[5];

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high(input int m);
        wait_clk(H);
        cs_n[m] = 1'b1;
        wait_clk(8);
    endtask

    // Mode 0 (m=0): MOSI set before the rising sample edge. Mode 3 (m=1): MOSI
    // changes on the falling leading edge and both sides sample on the rise.
    task automatic xfer_bits(input int m, input logic [W-1:0] tx, input int n,
                             output logic [W-1:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            if (m == 0) begin
                mosi[m] = tx[W-1-i];
                wait_clk(H);
                sck[m] = 1'b1;
                cap = {cap[W-2:0], miso[m]};
                wait_clk(H);
                sck[m] = 1'b0;
            end else begin
                wait_clk(H);
                sck[m] = 1'b0;
                mosi[m] = tx[W-1-i];
                wait_clk(H);
                cap = {cap[W-2:0], miso[m]};
                sck[m] = 1'b1;
            end
        end
    endtask

    task automatic tx_write(input int m, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        while (!tx_ready[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("tx_write_ready", tx_ready[m], 1'b1);
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic rx_take(input int m);
        @(negedge clk);
        rx_ready[m] = 1'b1;
        @(negedge clk);
        rx_ready[m] = 1'b0;
        check1("rx_valid_after_take", rx_valid[m], 1'b0);
    endtask

    task automatic clr_pulse(input int m);
`ifdef SPI_SLV_STATUS_EN
        @(negedge clk);
        clr_status[m] = 1'b1;
        @(negedge clk);
        clr_status[m] = 1'b0;
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] cap, cap2;

        vecs[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
        vecs[1] = '{0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[2] = '{1, 1'b1, 8'h96, 8'h69, 8'h96, 8'h69, 1'b0};
        vecs[3] = '{0, 1'b1, 8'h01, 8'hFE, 8'h01, 8'hFE, 1'b1};
        vecs[4] = '{1, 1'b0, 8'h00, 8'h80, 8'hFF, 8'h80, 1'b1};

        rst      = 1'b1;
        sck      = 2'b10;
        cs_n     = 2'b11;
        mosi     = 2'b00;
        tx_data  = '0;
        tx_valid = 2'b00;
        rx_ready = 2'b00;
`ifdef SPI_SLV_STATUS_EN
        clr_status = 2'b00;
`endif
        wait_clk(3);
        check1("rst_miso", miso[0], 1'b0);
        check1("rst_miso_oe", miso_oe[0], 1'b0);
        check1("rst_tx_ready", tx_ready[0], 1'b1);
        check8("rst_rx_data", rx_data[0], 8'h00);
        check1("rst_rx_valid", rx_valid[0], 1'b0);
        check1("rst_busy", busy[1], 1'b0);
`ifdef SPI_SLV_STATUS_EN
        check1("rst_overrun", overrun[0], 1'b0);
        check1("rst_underrun", underrun[0], 1'b0);
`endif
        rst = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 5; i++) begin
            clr_pulse(vecs[i].m);
            if (vecs[i].pre) tx_write(vecs[i].m, vecs[i].tx);
            cs_low(vecs[i].m);
            check1($sformatf("v%0d_busy", i), busy[vecs[i].m], 1'b1);
            xfer_bits(vecs[i].m, vecs[i].mosi_byte, W, cap);
            cs_high(vecs[i].m);
            check8($sformatf("v%0d_miso", i), cap, vecs[i].exp_miso);
            check1($sformatf("v%0d_rx_valid", i), rx_valid[vecs[i].m], 1'b1);
            check8($sformatf("v%0d_rx_data", i), rx_data[vecs[i].m], vecs[i].exp_rx);
`ifdef SPI_SLV_STATUS_EN
            check1($sformatf("v%0d_underrun", i), underrun[vecs[i].m], vecs[i].exp_und);
`endif
            wait_clk(5);
            check1($sformatf("v%0d_rx_held", i), rx_valid[vecs[i].m], 1'b1);
            rx_take(vecs[i].m);
        end

        // Mode 3 two-word frame, second word written while busy.
        clr_pulse(1);
        tx_write(1, 8'h12);
        cs_low(1);
        xfer_bits(1, 8'h5A, W, cap);
        wait_clk(4);
        check1("m3_w1_valid", rx_valid[1], 1'b1);
        check8("m3_w1_rx", rx_data[1], 8'h5A);
        rx_take(1);
        tx_write(1, 8'h34);
        xfer_bits(1, 8'hC3, W, cap2);
        cs_high(1);
        check8("m3_w1_miso", cap, 8'h12);
        check8("m3_w2_miso", cap2, 8'h34);
        check8("m3_w2_rx", rx_data[1], 8'hC3);
`ifdef SPI_SLV_STATUS_EN
        check1("m3_no_underrun", underrun[1], 1'b0);
        clr_pulse(0);
        clr_pulse(0);
        check1("underrun_cleared", underrun[0], 1'b0);
`endif
        rx_take(1);

        // Two words without taking: second word overwrites.
        clr_pulse(0);
        cs_low(0);
        xfer_bits(0, 8'h11, W, cap);
        xfer_bits(0, 8'h22, W, cap);
        cs_high(0);
        check1("ovr_valid", rx_valid[0], 1'b1);
        check8("ovr_rx_data", rx_data[0], 8'h22);
`ifdef SPI_SLV_STATUS_EN
        check1("ovr_flag", overrun[0], 1'b1);
`endif
        rx_take(0);

        // CS released after 3 bits, then a full word.
        cs_low(0);
        xfer_bits(0, 8'hE0, 3, cap);
        cs_high(0);
        check1("partial_no_valid", rx_valid[0], 1'b0);
        check1("partial_idle", busy[0], 1'b0);
        cs_low(0);
        xfer_bits(0, 8'h81, W, cap);
        cs_high(0);
        check1("after_partial_valid", rx_valid[0], 1'b1);
        check8("after_partial_rx", rx_data[0], 8'h81);
        rx_take(0);

        // Mode 3: CS pulse without SCK edges keeps the holding register.
        tx_write(1, 8'h5C);
        cs_low(1);
        cs_high(1);
        check1("hold_kept_ready", tx_ready[1], 1'b0);
        cs_low(1);
        xfer_bits(1, 8'h00, W, cap);
        cs_high(1);
        check8("hold_kept_miso", cap, 8'h5C);
        rx_take(1);

        // Reset mid-frame with a pending RX word and a full holding register.
        cs_low(0);
        xfer_bits(0, 8'h81, W, cap);
        xfer_bits(0, 8'hF0, 4, cap);
        tx_write(0, 8'h77);
        check1("pre_rst_busy", busy[0], 1'b1);
        check1("pre_rst_oe", miso_oe[0], 1'b1);
        check1("pre_rst_tx_ready", tx_ready[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check1("mid_rst_miso", miso[0], 1'b0);
        check1("mid_rst_oe", miso_oe[0], 1'b0);
        check1("mid_rst_tx_ready", tx_ready[0], 1'b1);
        check8("mid_rst_rx_data", rx_data[0], 8'h00);
        check1("mid_rst_rx_valid", rx_valid[0], 1'b0);
        check1("mid_rst_busy", busy[0], 1'b0);
        sck[0]  = 1'b0;
        cs_n[0] = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
